// File: rtl/fp_norm_lzc_if.sv
// fp_norm_lzc_if: handshake bundle for the fp_norm_lzc normalization stage.
//   Input side : in_valid, in_ready, in_sign, in_exp[EXP_W], in_sig[24]
//   Output side: out_valid, out_ready, out_sign, out_exp[EXP_W], out_frac[23],
//                out_shamt[5], out_zero, out_uflow
// Modports: master = producer/consumer around the stage, slave = the stage itself.
interface fp_norm_lzc_if #(
  parameter int unsigned EXP_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [23:0]      in_sig;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [22:0]      out_frac;
  logic [4:0]       out_shamt;
  logic             out_zero;
  logic             out_uflow;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac, out_shamt, out_zero, out_uflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac, out_shamt, out_zero, out_uflow
  );
endinterface

// File: rtl/fp_norm_lzc.sv
// fp_norm_lzc: two-stage leading-zero count and exponent adjust for single-precision
// add/sub normalization. S1 registers the beat with partial LZ counts of the upper
// 16 and lower 8 significand bits; S2 combines them and registers the final results.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fp_norm_lzc_if.slave (valid/ready in, valid/ready out, see interface)
// Optional feature: define FP_NORM_GRADUAL_UFLOW_EN for gradual underflow
// (shift to subnormal); otherwise underflow flushes to zero.
// EXP_W must be at least 5.
module fp_norm_lzc #(
  parameter int unsigned EXP_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  fp_norm_lzc_if.slave bus
);

  function automatic logic [4:0] lz16(input logic [15:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd16;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(15 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] lz8(input logic [7:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd8;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(7 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // S1 state
  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [22:0]      s1_frac;
  logic [4:0]       s1_hi_lz;
  logic [3:0]       s1_lo_lz;
  logic             s1_hi_zero;
  logic             s1_lo_zero;

  // S2 state (drives the outputs directly)
  logic             s2_valid;
  logic             s2_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [22:0]      s2_frac;
  logic [4:0]       s2_shamt;
  logic             s2_zero;
  logic             s2_uflow;

  logic s2_adv;
  logic s1_adv;
  logic in_ready;

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = s2_adv;
  // Gated by rst_n so nothing is accepted on a reset cycle.
  assign in_ready = rst_n && (!s1_valid || s1_adv);

  // S2 next-state
  logic [4:0]       n_cnt;
  logic [EXP_W:0]   n_ext;
  logic [EXP_W:0]   exp_diff;
  logic             is_zero;
  logic             is_normal;
  logic [EXP_W-1:0] nxt_exp;
  logic [4:0]       nxt_shamt;
  logic             nxt_zero;
  logic             nxt_uflow;

  always_comb begin
    n_cnt     = s1_hi_zero ? (5'd16 + {1'b0, s1_lo_lz}) : s1_hi_lz;
    n_ext     = {{(EXP_W - 4){1'b0}}, n_cnt};
    exp_diff  = {1'b0, s1_exp} - n_ext;
    is_zero   = s1_hi_zero && s1_lo_zero;
    // exp > n: no borrow out of the widened subtract and a non-zero result
    is_normal = !exp_diff[EXP_W] && (exp_diff != '0);
    nxt_exp   = '0;
    nxt_shamt = '0;
    nxt_zero  = 1'b0;
    nxt_uflow = 1'b0;
    if (is_zero) begin
      nxt_zero = 1'b1;
    end else if (is_normal) begin
      nxt_exp   = exp_diff[EXP_W-1:0];
      nxt_shamt = n_cnt;
    end else begin
      nxt_uflow = 1'b1;
`ifdef FP_NORM_GRADUAL_UFLOW_EN
      // Underflow implies exp <= n <= 24, so the low 5 bits hold exp exactly.
      nxt_shamt = (s1_exp == '0) ? 5'd0 : (s1_exp[4:0] - 5'd1);
`else
      nxt_zero  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_frac    <= '0;
      s1_hi_lz   <= '0;
      s1_lo_lz   <= '0;
      s1_hi_zero <= 1'b0;
      s1_lo_zero <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign    <= bus.in_sign;
        s1_exp     <= bus.in_exp;
        s1_frac    <= bus.in_sig[22:0];
        s1_hi_lz   <= lz16(bus.in_sig[23:8]);
        s1_lo_lz   <= lz8(bus.in_sig[7:0]);
        s1_hi_zero <= (bus.in_sig[23:8] == '0);
        s1_lo_zero <= (bus.in_sig[7:0] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_frac  <= '0;
      s2_shamt <= '0;
      s2_zero  <= 1'b0;
      s2_uflow <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign  <= s1_sign;
        s2_exp   <= nxt_exp;
        s2_frac  <= s1_frac;
        s2_shamt <= nxt_shamt;
        s2_zero  <= nxt_zero;
        s2_uflow <= nxt_uflow;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_sign  = s2_sign;
  assign bus.out_exp   = s2_exp;
  assign bus.out_frac  = s2_frac;
  assign bus.out_shamt = s2_shamt;
  assign bus.out_zero  = s2_zero;
  assign bus.out_uflow = s2_uflow;

endmodule

// File: tb/tb_fp_norm_lzc.sv
// tb_fp_norm_lzc: directed and randomized bench for fp_norm_lzc against a
// behavioural model (leading zeros via log2, exponent rules via integer math).
module tb_fp_norm_lzc;
  localparam int unsigned EW = 8;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [22:0]   frac;
    logic [4:0]    shamt;
    logic          zero;
    logic          uflow;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_lzc_if #(.EXP_W(EW)) bus ();

  fp_norm_lzc #(.EXP_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
  endtask

  function automatic res_t model(input logic sign, input logic [EW-1:0] e, input logic [23:0] sig);
    res_t r;
    int   n;
    int   ei;
    ei = int'(e);
    n  = (sig == 0) ? 24 : 24 - $clog2(int'(sig) + 1);
    r  = '0;
    r.sign = sign;
    r.frac = sig[22:0];
    if (sig == 0) begin
      r.zero = 1'b1;
    end else if (ei > n) begin
      r.exp   = EW'(ei - n);
      r.shamt = 5'(n);
    end else begin
      r.uflow = 1'b1;
`ifdef FP_NORM_GRADUAL_UFLOW_EN
      r.shamt = (ei == 0) ? 5'd0 : 5'(ei - 1);
`else
      r.zero  = 1'b1;
`endif
    end
    return r;
  endfunction

  function automatic res_t dut_out();
    res_t r;
    r.sign  = bus.out_sign;
    r.exp   = bus.out_exp;
    r.frac  = bus.out_frac;
    r.shamt = bus.out_shamt;
    r.zero  = bus.out_zero;
    r.uflow = bus.out_uflow;
    return r;
  endfunction

  // Scoreboard monitor: sampled mid-cycle, inputs change just after posedge.
  res_t q[$];
  logic rst_chk = 1'b0;

  always @(negedge clk) begin
    if (rst_chk) chk("reset_outputs", {bus.out_valid, dut_out()}, '0);
    if (!rst_n) begin
      chk("in_ready_in_reset", bus.in_ready, 1'b0);
      q.delete();
      rst_chk = 1'b1;
    end else begin
      rst_chk = 1'b0;
      if (bus.out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 1'b1, 1'b0);
        else begin
          chk("model_compare", dut_out(), q[0]);
          if (bus.out_ready) void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_sign, bus.in_exp, bus.in_sig));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic s, input logic [EW-1:0] e, input logic [23:0] sig);
    int k;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_sig   = sig;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (k >= 50) chk("send_timeout", 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Single beat, out_ready=1: out_valid must appear exactly 2 edges after accept.
  task automatic directed(input string name, input logic [EW-1:0] e, input logic [23:0] sig,
                          input logic [EW-1:0] w_exp, input logic [4:0] w_sh,
                          input logic w_zero, input logic w_uflow);
    send(1'b1, e, sig);
    @(negedge clk);
    chk({name, "_lat1"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_lat2"}, bus.out_valid, 1'b1);
    chk({name, "_exp"}, bus.out_exp, w_exp);
    chk({name, "_shamt"}, bus.out_shamt, w_sh);
    chk({name, "_frac"}, bus.out_frac, sig[22:0]);
    chk({name, "_flags"}, {bus.out_sign, bus.out_zero, bus.out_uflow}, {1'b1, w_zero, w_uflow});
    step();
  endtask

  initial begin
    int acc;
    int run;
    int k;
    logic fire;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_sig    = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready", bus.in_ready, 1'b1);
    step();

    directed("normal", 8'd130, 24'h008000, 8'd122, 5'd8, 1'b0, 1'b0);
    directed("normalized", 8'd100, 24'h800001, 8'd100, 5'd0, 1'b0, 1'b0);
    directed("zero", 8'd77, 24'h000000, 8'd0, 5'd0, 1'b1, 1'b0);
    directed("exp_bound", 8'd16, 24'h000100, 8'd1, 5'd15, 1'b0, 1'b0);
`ifdef FP_NORM_GRADUAL_UFLOW_EN
    directed("uflow", 8'd5, 24'h000100, 8'd0, 5'd4, 1'b0, 1'b1);
    directed("uflow_b", 8'd15, 24'h000100, 8'd0, 5'd14, 1'b0, 1'b1);
    directed("uflow_e0", 8'd0, 24'h000100, 8'd0, 5'd0, 1'b0, 1'b1);
`else
    directed("uflow", 8'd5, 24'h000100, 8'd0, 5'd0, 1'b1, 1'b1);
    directed("uflow_b", 8'd15, 24'h000100, 8'd0, 5'd0, 1'b1, 1'b1);
    directed("uflow_e0", 8'd0, 24'h000100, 8'd0, 5'd0, 1'b1, 1'b1);
`endif

    // Backpressure: 4 beats offered back-to-back, out_ready low for 5 cycles.
    bus.out_ready = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_exp = EW'(40 + acc);
      bus.in_sig = 24'h000001 << (acc * 3);
      bus.in_sign = acc[0];
      @(negedge clk);
      fire = bus.in_ready;
      step();
      if (fire) acc++;
    end
    chk("bp_accepts", acc, 2);
    @(negedge clk);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    step();
    bus.out_ready = 1'b1;
    run = 0;
    for (int c = 0; c < 8; c++) begin
      if (acc < 4) begin
        bus.in_valid = 1'b1;
        bus.in_exp = EW'(40 + acc);
        bus.in_sig = 24'h000001 << (acc * 3);
        bus.in_sign = acc[0];
      end else bus.in_valid = 1'b0;
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      if (c < 4 && bus.out_valid) run++;
      step();
      if (fire) acc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_burst_len", run, 4);
    chk("bp_drained", q.size(), 0);

    // Reset with 2 beats in flight.
    bus.out_ready = 1'b0;
    send(1'b1, 8'd90, 24'h00F000);
    send(1'b0, 8'd91, 24'h000F00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    step();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_stale", bus.out_valid, 1'b0);
      step();
    end
    directed("after_rst", 8'd130, 24'h008000, 8'd122, 5'd8, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      step();
      rst_n = ($urandom_range(0, 249) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || fire) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_sign  = 1'($urandom);
        bus.in_sig   = 24'($urandom) >> $urandom_range(0, 24);
        bus.in_exp   = ($urandom_range(0, 2) == 0) ? EW'($urandom_range(0, 30)) : EW'($urandom);
      end
    end
    bus.in_valid  = 1'b0;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    chk("final_drain", q.size(), 0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fp_norm_lzc.md
# fp_norm_lzc

Two-stage pipelined leading-zero-count and exponent-adjust stage for single-precision add/sub normalization. Takes the 24-bit unnormalized significand (hidden-bit position at bit 23) and biased exponent from the subtract path. Produces the left-shift amount, adjusted exponent and 23-bit fraction, which feed `left_shifter_23` directly downstream. Valid/ready handshake on both sides, full throughput of one result per cycle.

## Interface
- `EXP_W`, default 8: exponent width, biased.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `in_sign`  in  1  result sign, passed through.
- `in_exp`  in  EXP_W  biased exponent before normalization.
- `in_sig`  in  24  unnormalized significand. Bit 23 is the hidden-bit position. Any carry-out is already handled upstream.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `out_sign`  out  1  registered `in_sign`.
- `out_exp`  out  EXP_W  adjusted biased exponent.
- `out_frac`  out  23  registered `in_sig[22:0]`, unshifted. Feeds the shifter `in` port.
- `out_shamt`  out  5  left-shift amount. Feeds the shifter `shift_amt` port.
- `out_zero`  out  1  result is zero.
- `out_uflow`  out  1  normalization underflowed the exponent range.

## Operation
- n = leading zeros of `in_sig`, counted from bit 23. Range 0..24.
- **Stage 1 (S1):**
  - Registers the beat.
  - Computes partial counts: lz of `in_sig[23:8]` (0..16) and lz of `in_sig[7:0]` (0..8), plus an all-zero flag for each half.
- **Stage 2 (S2):**
  - Combines the partials: n = hi_lz if the upper half is non-zero, else 16 + lo_lz.
  - Computes the exponent result and registers all outputs.
- **Zero case:** `in_sig` == 0 gives `out_zero`=1, `out_exp`=0, `out_shamt`=0, `out_uflow`=0.
- **Normal case:** `in_sig` != 0 and `in_exp` > n.
  - `out_exp` = `in_exp` − n, `out_shamt` = n, `out_uflow`=0.
  - Boundary: `in_exp` == n+1 gives `out_exp`=1, which is normal.
- **Underflow case:** `in_sig` != 0 and `in_exp` <= n. The behaviour depends on the macro (see Configuration).
- Subtraction is performed at EXP_W+1 bits; no wrap-around reaches `out_exp`.
- `out_frac` is never modified here. Shifting `out_frac` by `out_shamt` equals `(in_sig << n)[22:0]`, because `in_sig[23]`=0 whenever n >= 1.

## Timing
- Latency: 2 cycles from input handshake (`in_valid`&`in_ready`) to `out_valid` with no backpressure. Throughput is 1 beat per cycle.
- S2 advances when it is empty or `out_ready`=1. S1 advances when S2 advances.
- `in_ready` = !S1_valid | S1_advance. It is combinational from `out_ready`.
- `in_ready` is 0 during any cycle in which `rst_n`=0.
- While `out_valid`=1 and `out_ready`=0:
  - every output holds stable;
  - at most 2 beats are buffered (S1+S2) before `in_ready` drops.
- Beats are never dropped, duplicated or reordered.
- Input is sampled only on handshake. Data with `in_valid`=0 is ignored.
- Reset values (any cycle with `rst_n`=0, including mid-transfer):
  - S1/S2 valid = 0; all in-flight beats are discarded;
  - `out_valid`=0, `out_sign`=0, `out_exp`=0, `out_frac`=0, `out_shamt`=0, `out_zero`=0, `out_uflow`=0.
  - The first accept is possible in the cycle after `rst_n` returns to 1.

## Configuration
- Macro: `FP_NORM_GRADUAL_UFLOW_EN`.
- **Defined (gradual underflow):**
  - `out_exp`=0, `out_uflow`=1, `out_zero`=0.
  - `out_shamt` = `in_exp` − 1, or 0 when `in_exp`=0.
  - The downstream shift then yields the subnormal fraction.
- **Undefined (flush-to-zero):**
  - `out_zero`=1, `out_uflow`=1, `out_exp`=0, `out_shamt`=0.
  - `out_frac` is still the raw `in_sig[22:0]`. Downstream must select zero on `out_zero`.

## Test plan
- **Single normal beat:** `in_exp`=130, `in_sig`=24'h008000, `out_ready`=1 -> 2 cycles later `out_shamt`=8, `out_exp`=122, `out_frac`=23'h008000, `out_zero`=0, `out_uflow`=0.
- **Already normalized:** `in_sig`=24'h800001, `in_exp`=100 -> `out_shamt`=0, `out_exp`=100. **Zero:** `in_sig`=0 -> `out_zero`=1, `out_exp`=0, `out_shamt`=0.
- **Underflow:** `in_exp`=5, `in_sig`=24'h000100 (n=15).
  - Macro undefined -> `out_zero`=1, `out_uflow`=1, `out_shamt`=0, `out_exp`=0.
  - Macro defined -> `out_shamt`=4, `out_exp`=0, `out_uflow`=1, `out_zero`=0.
- **Exponent boundary:** `in_exp`=16, `in_sig`=24'h000100 -> `out_exp`=1, `out_shamt`=15, `out_uflow`=0. `in_exp`=15 -> underflow path.
- **Backpressure:** stream 4 beats back-to-back, `out_ready`=0 for 5 cycles.
  - `in_ready` falls after 2 accepts; outputs hold stable.
  - On release, all 4 results emerge in order at 1 per cycle.
- **Reset mid-operation:** 2 beats in flight, `rst_n`=0 for 1 cycle -> next cycle `out_valid`=0 with all outputs 0, no stale beat emerges, and a new beat is accepted the cycle after release.
